// File: rtl/sd_spi_pkg.sv
// ------------------------------------------------------------------
// sd_spi_pkg : shared states and register map for the SD SPI APB sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package sd_spi_pkg;

  typedef enum logic [3:0] {
    S_INIT_CTRL = 4'd0,
    S_INIT_DIV  = 4'd1,
    S_INIT_SS   = 4'd2,
    S_IDLE      = 4'd3,
    S_CFG_DIV   = 4'd4,
    S_SSEL_WR   = 4'd5,
    S_TX_WR     = 4'd6,
    S_POLL      = 4'd7,
    S_RX_RD     = 4'd8,
    S_RSP       = 4'd9,
    S_ERR       = 4'd10
  } seq_state_e;

  localparam logic [6:0] CTRL_ADDR_DEF   = 7'h00;
  localparam logic [6:0] RXDATA_ADDR_DEF = 7'h08;
  localparam logic [6:0] TXDATA_ADDR_DEF = 7'h0C;
  localparam logic [6:0] STAT_ADDR_DEF   = 7'h20;
  localparam logic [6:0] SSEL_ADDR_DEF   = 7'h24;
  localparam logic [6:0] CLKDIV_ADDR_DEF = 7'h2C;
  localparam logic [7:0] CTRL_INIT_DEF   = 8'h03;
  localparam int         RXEMPTY_BIT_DEF = 2;
  localparam int         POLL_LIMIT_DEF  = 1023;
  localparam logic [7:0] CLKDIV_RST_DEF  = 8'd63;

  // States that own an APB transfer in flight.
  function automatic logic is_access(seq_state_e s);
    return !(s == S_IDLE || s == S_RSP || s == S_ERR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_spi_apb_seq_xfer.sv
// ------------------------------------------------------------------
// apb_master_xfer : single APB3 transfer engine (SETUP then ACCESS until PREADY)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module apb_master_xfer (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       start_i,
  input  logic       write_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       slverr_o,
  output logic [6:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR
);

  logic       psel_q;
  logic       penable_q;
  logic       pwrite_q;
  logic [6:0] paddr_q;
  logic [7:0] pwdata_q;

  // A start in the completion cycle chains straight into a new SETUP phase.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else if (start_i) begin
      psel_q    <= 1'b1;
      penable_q <= 1'b0;
      pwrite_q  <= write_i;
      paddr_q   <= addr_i;
      pwdata_q  <= wdata_i;
    end else if (psel_q && !penable_q) begin
      penable_q <= 1'b1;
    end else if (done_o) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end
  end

  assign done_o   = psel_q & penable_q & PREADY;
  assign busy_o   = psel_q;
  assign rdata_o  = PRDATA;
  assign slverr_o = PSLVERR;

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

`default_nettype wire

// File: rtl/sd_spi_apb_seq.sv
// ------------------------------------------------------------------
// sd_spi_apb_seq : byte-exchange stream to SD SPI controller register sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sd_spi_apb_seq
  import sd_spi_pkg::*;
#(
  parameter logic [6:0] CTRL_ADDR   = CTRL_ADDR_DEF,
  parameter logic [6:0] RXDATA_ADDR = RXDATA_ADDR_DEF,
  parameter logic [6:0] TXDATA_ADDR = TXDATA_ADDR_DEF,
  parameter logic [6:0] STAT_ADDR   = STAT_ADDR_DEF,
  parameter logic [6:0] SSEL_ADDR   = SSEL_ADDR_DEF,
  parameter logic [6:0] CLKDIV_ADDR = CLKDIV_ADDR_DEF,
  parameter logic [7:0] CTRL_INIT   = CTRL_INIT_DEF,
  parameter int         RXEMPTY_BIT = RXEMPTY_BIT_DEF,
  parameter int         POLL_LIMIT  = POLL_LIMIT_DEF,
  parameter logic [7:0] CLKDIV_RST  = CLKDIV_RST_DEF
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_data,
  input  logic       req_cs,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic [7:0] cfg_clkdiv,
  input  logic       cfg_update,
  output logic       busy,
  output logic       err,
  input  logic       err_clr,
  output logic [6:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR
);

  localparam logic [9:0] POLL_LAST = 10'(POLL_LIMIT - 1);

  seq_state_e state_q, state_d;
  logic       ss_q;
  logic       cs_q;
  logic [7:0] tx_q;
  logic [7:0] div_q;
  logic       cfg_pend_q, cfg_pend_d;
  logic [9:0] poll_cnt_q, poll_cnt_d;
  logic [7:0] rsp_data_q;
  logic       err_q, err_d;

  logic       x_start, x_write, x_busy, x_done, x_slverr;
  logic [6:0] x_addr;
  logic [7:0] x_wdata, x_rdata;
  logic       accept;
  logic       w_cs;
  logic [7:0] w_tx;
  logic [7:0] w_div;

  apb_master_xfer u_xfer (
    .PCLK     (PCLK),
    .PRESETN  (PRESETN),
    .start_i  (x_start),
    .write_i  (x_write),
    .addr_i   (x_addr),
    .wdata_i  (x_wdata),
    .busy_o   (x_busy),
    .done_o   (x_done),
    .rdata_o  (x_rdata),
    .slverr_o (x_slverr),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  // A pending or same-cycle divider update blocks request acceptance.
  assign req_ready = (state_q == S_IDLE) && !cfg_pend_q && !cfg_update;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

  assign w_cs  = (state_q == S_IDLE) ? req_cs   : cs_q;
  assign w_tx  = (state_q == S_IDLE) ? req_data : tx_q;
  assign w_div = cfg_update ? cfg_clkdiv : div_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT_CTRL: if (x_done) state_d = S_INIT_DIV;
      S_INIT_DIV:  if (x_done) state_d = S_INIT_SS;
      S_INIT_SS,
      S_CFG_DIV:   if (x_done) state_d = S_IDLE;
      S_IDLE: begin
        if (cfg_update || cfg_pend_q) state_d = S_CFG_DIV;
        else if (req_valid)           state_d = (req_cs != ss_q) ? S_SSEL_WR : S_TX_WR;
      end
      S_SSEL_WR:   if (x_done) state_d = S_TX_WR;
      S_TX_WR:     if (x_done) state_d = S_POLL;
      S_POLL: begin
        if (x_done) begin
          if (!x_rdata[RXEMPTY_BIT])     state_d = S_RX_RD;
          else if (poll_cnt_q == POLL_LAST) state_d = S_ERR;
        end
      end
      S_RX_RD:     if (x_done) state_d = S_RSP;
      S_RSP:       state_d = S_IDLE;
      S_ERR:       if (err_clr) state_d = S_IDLE;
      default:     state_d = S_ERR;
    endcase
    if (x_done && x_slverr) state_d = S_ERR;
  end

  // The next access is launched from the cycle that decides it, so each
  // transfer costs exactly SETUP + ACCESS with no idle gap in between.
  always_comb begin
    x_start = is_access(state_d) && (!x_busy || x_done);
    x_write = 1'b1;
    x_addr  = '0;
    x_wdata = '0;
    case (state_d)
      S_INIT_CTRL: begin x_addr = CTRL_ADDR;   x_wdata = CTRL_INIT;  end
      S_INIT_DIV:  begin x_addr = CLKDIV_ADDR; x_wdata = CLKDIV_RST; end
      S_INIT_SS:   begin x_addr = SSEL_ADDR;   x_wdata = 8'h00;      end
      S_CFG_DIV:   begin x_addr = CLKDIV_ADDR; x_wdata = w_div;      end
      S_SSEL_WR:   begin x_addr = SSEL_ADDR;   x_wdata = {7'b0, w_cs}; end
      S_TX_WR:     begin x_addr = TXDATA_ADDR; x_wdata = w_tx;       end
      S_POLL:      begin x_addr = STAT_ADDR;   x_write = 1'b0;       end
      S_RX_RD:     begin x_addr = RXDATA_ADDR; x_write = 1'b0;       end
      default:     ;
    endcase
  end

  always_comb begin
    cfg_pend_d = cfg_pend_q;
    if (state_q == S_IDLE) cfg_pend_d = 1'b0;
    else if (cfg_update)   cfg_pend_d = 1'b1;

    poll_cnt_d = poll_cnt_q;
    if (state_d == S_TX_WR && state_q != S_TX_WR)  poll_cnt_d = '0;
    else if (state_q == S_POLL && x_done)          poll_cnt_d = poll_cnt_q + 10'd1;

    err_d = err_q;
    if (state_d == S_ERR && state_q != S_ERR) err_d = 1'b1;
    else if (err_clr)                         err_d = 1'b0;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= S_INIT_CTRL;
      ss_q       <= 1'b0;
      cs_q       <= 1'b0;
      tx_q       <= '0;
      div_q      <= '0;
      cfg_pend_q <= 1'b0;
      poll_cnt_q <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_pend_q <= cfg_pend_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
      if (accept) begin
        cs_q <= req_cs;
        tx_q <= req_data;
      end
      if (cfg_update) div_q <= cfg_clkdiv;
      if (state_q == S_SSEL_WR && x_done && !x_slverr) ss_q <= cs_q;
      if (state_q == S_RX_RD && x_done && !x_slverr)   rsp_data_q <= x_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_spi_apb_seq.sv
// ------------------------------------------------------------------
// tb_sd_spi_apb_seq : randomized bench with APB slave model and transaction scoreboard
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_sd_spi_apb_seq;

  typedef struct packed {
    logic       w;
    logic [6:0] a;
    logic [7:0] d;
  } xact_t;

  logic       PCLK = 1'b0;
  logic       PRESETN = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_data = 8'h00;
  logic       req_cs = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] cfg_clkdiv = 8'h00;
  logic       cfg_update = 1'b0;
  logic       busy;
  logic       err;
  logic       err_clr = 1'b0;
  logic [6:0] PADDR;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = 8'h00;
  logic       PREADY = 1'b0;
  logic       PSLVERR = 1'b0;

  sd_spi_apb_seq dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_cs(req_cs),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cfg_clkdiv(cfg_clkdiv), .cfg_update(cfg_update),
    .busy(busy), .err(err), .err_clr(err_clr),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave configuration, set by the sequencing code.
  bit         rand_wait = 1'b0;
  bit         hold_en = 1'b0;
  logic [6:0] hold_addr = 7'h00;
  int         hold_n = 0;
  int         stat_empty_left = 0;
  logic [7:0] rx_val = 8'h00;
  bit         err_en = 1'b0;
  logic [6:0] err_addr = 7'h00;

  xact_t      log_q[$];
  int         waits_total = 0;
  int         last_done_cyc = 0;
  logic [7:0] rsp_q[$];
  int         rsp_cyc_q[$];

  // APB slave: drives responses on the falling edge and logs every completed access.
  initial begin
    bit         seen_setup;
    bit         wdecided;
    bit         chk_drop;
    int         wleft;
    logic [15:0] snap;
    logic [7:0] rd;
    seen_setup = 0; wdecided = 0; chk_drop = 0; wleft = 0; snap = '0;
    forever begin
      @(negedge PCLK);
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = 8'($urandom);
      if (!PRESETN) begin
        seen_setup = 0; wdecided = 0; chk_drop = 0;
        continue;
      end
      if (chk_drop) begin
        chk_val("apb_enable_drop", 32'(PENABLE), 32'd0);
        chk_drop = 0;
      end
      if (wdecided && !PENABLE) chk_val("apb_access_abort", 32'(PENABLE), 32'd1);
      if (PSEL && !PENABLE) begin
        seen_setup = 1;
        wdecided   = 0;
        snap       = {PWRITE, PADDR, PWDATA};
      end else if (PSEL && PENABLE) begin
        chk_val("apb_setup_first", 32'(seen_setup), 32'd1);
        chk_val("apb_stable", 32'({PWRITE, PADDR, PWDATA}), 32'(snap));
        if (!wdecided) begin
          if (hold_en && PADDR == hold_addr) wleft = hold_n;
          else if (rand_wait)                wleft = int'($urandom_range(0, 3));
          else                               wleft = 0;
          wdecided = 1;
        end
        if (wleft > 0) begin
          wleft--;
          waits_total++;
        end else begin
          PREADY = 1'b1;
          if (PWRITE) begin
            log_q.push_back({1'b1, PADDR, PWDATA});
          end else begin
            if (PADDR == 7'h20) begin
              rd = 8'($urandom) & 8'hFB;
              if (stat_empty_left > 0) begin
                rd = rd | 8'h04;
                stat_empty_left--;
              end
            end else if (PADDR == 7'h08) begin
              rd = rx_val;
            end else begin
              rd = 8'($urandom);
            end
            PRDATA = rd;
            log_q.push_back({1'b0, PADDR, 8'h00});
          end
          if (err_en && PADDR == err_addr) begin
            PSLVERR = 1'b1;
            err_en  = 0;
          end
          last_done_cyc = cyc;
          seen_setup = 0;
          wdecided   = 0;
          chk_drop   = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge PCLK);
      if (PRESETN && rsp_valid) begin
        rsp_q.push_back(rsp_data);
        rsp_cyc_q.push_back(cyc);
      end
    end
  end

  logic       ss_m = 1'b0;
  logic [7:0] last_rsp = 8'h00;

  task automatic cmp_log(input xact_t exp_q[$]);
    int n;
    chk_val("xact_count", 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk_val($sformatf("xact%0d", i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  // cfg_mode: 0 none, 1 pulse after acceptance, 2 pulse together with req_valid.
  // fault: 0 none, 1 status never ready, 2 PSLVERR on RX read, 3 PSLVERR on TX write.
  task automatic do_byte(input logic [7:0] d, input logic cs, input int n_empty,
                         input logic [7:0] rx, input bit rw, input int cfg_mode,
                         input logic [7:0] cdiv, input int fault);
    xact_t exp_q[$];
    int    k, acc_cyc, w0, n_x, polls, lat_exp;
    bit    exp_err;
    log_q.delete(); rsp_q.delete(); rsp_cyc_q.delete();
    rand_wait       = rw;
    stat_empty_left = (fault == 1) ? 1 << 20 : n_empty;
    rx_val          = rx;
    err_en          = (fault >= 2);
    err_addr        = (fault == 2) ? 7'h08 : 7'h0C;
    exp_err         = (fault != 0);

    if (cfg_mode == 2) exp_q.push_back({1'b1, 7'h2C, cdiv});
    n_x = 0;
    if (cs != ss_m) begin
      exp_q.push_back({1'b1, 7'h24, {7'b0, cs}});
      ss_m = cs;
      n_x++;
    end
    exp_q.push_back({1'b1, 7'h0C, d});
    n_x++;
    if (fault != 3) begin
      polls = (fault == 1) ? 1023 : n_empty + 1;
      for (int i = 0; i < polls; i++) exp_q.push_back({1'b0, 7'h20, 8'h00});
      n_x += polls;
      if (fault != 1) begin
        exp_q.push_back({1'b0, 7'h08, 8'h00});
        n_x++;
      end
    end
    if (cfg_mode == 1) exp_q.push_back({1'b1, 7'h2C, cdiv});

    @(negedge PCLK);
    req_valid = 1'b1; req_data = d; req_cs = cs;
    if (cfg_mode == 2) begin
      cfg_update = 1'b1; cfg_clkdiv = cdiv;
      @(negedge PCLK);
      cfg_update = 1'b0;
    end
    k = 0;
    while (!req_ready && k < 100) begin @(negedge PCLK); k++; end
    chk_val("req_ready", 32'(req_ready), 32'd1);
    chk_val("rsp_data_hold", 32'(rsp_data), 32'(last_rsp));
    acc_cyc = cyc;
    w0      = waits_total;
    @(negedge PCLK);
    req_valid = 1'b0; req_data = 8'($urandom); req_cs = 1'($urandom);
    chk_val("req_ready_drop", 32'(req_ready), 32'd0);
    if (cfg_mode == 1) begin
      cfg_update = 1'b1; cfg_clkdiv = cdiv;
      @(negedge PCLK);
      cfg_update = 1'b0;
    end

    k = 0;
    while (rsp_q.size() == 0 && !err && k < 6000) begin @(negedge PCLK); k++; end

    if (!exp_err) begin
      chk_val("rsp_seen", 32'(rsp_q.size()), 32'd1);
      if (rsp_q.size() > 0) begin
        chk_val("rsp_data", 32'(rsp_q[0]), 32'(rx));
        lat_exp = 1 + 2 * n_x + (waits_total - w0);
        chk_val("latency", 32'(rsp_cyc_q[0] - acc_cyc), 32'(lat_exp));
      end
      last_rsp = rx;
      k = 0;
      while (!req_ready && k < 100) begin @(negedge PCLK); k++; end
      chk_val("ready_after_rsp", 32'(req_ready), 32'd1);
      chk_val("rsp_pulse_count", 32'(rsp_q.size()), 32'd1);
      chk_val("err_clear", 32'(err), 32'd0);
      cmp_log(exp_q);
    end else begin
      chk_val("err_set", 32'(err), 32'd1);
      repeat (5) @(negedge PCLK);
      chk_val("err_no_rsp", 32'(rsp_q.size()), 32'd0);
      chk_val("err_busy", 32'(busy), 32'd1);
      chk_val("err_ready", 32'(req_ready), 32'd0);
      chk_val("err_psel", 32'(PSEL), 32'd0);
      cmp_log(exp_q);
      err_clr = 1'b1;
      @(negedge PCLK);
      err_clr = 1'b0;
      chk_val("err_cleared", 32'(err), 32'd0);
      chk_val("err_to_idle", 32'(req_ready), 32'd1);
      chk_val("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    xact_t init_q[$];
    int    k;

    repeat (3) @(negedge PCLK);
    chk_val("rst_psel",    32'(PSEL), 32'd0);
    chk_val("rst_penable", 32'(PENABLE), 32'd0);
    chk_val("rst_pwrite",  32'(PWRITE), 32'd0);
    chk_val("rst_paddr",   32'(PADDR), 32'd0);
    chk_val("rst_pwdata",  32'(PWDATA), 32'd0);
    chk_val("rst_ready",   32'(req_ready), 32'd0);
    chk_val("rst_rspv",    32'(rsp_valid), 32'd0);
    chk_val("rst_rspd",    32'(rsp_data), 32'd0);
    chk_val("rst_busy",    32'(busy), 32'd1);
    chk_val("rst_err",     32'(err), 32'd0);

    log_q.delete();
    PRESETN = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge PCLK); k++; end
    chk_val("init_ready", 32'(req_ready), 32'd1);
    chk_val("init_ready_delay", 32'(cyc - last_done_cyc), 32'd1);
    init_q.push_back({1'b1, 7'h00, 8'h03});
    init_q.push_back({1'b1, 7'h2C, 8'h3F});
    init_q.push_back({1'b1, 7'h24, 8'h00});
    cmp_log(init_q);

    do_byte(8'hFF, 1'b1, 0, 8'hA5, 1'b0, 0, 8'h00, 0);
    do_byte(8'hFF, 1'b1, 3, 8'h5A, 1'b0, 0, 8'h00, 0);

    hold_en = 1'b1; hold_addr = 7'h0C; hold_n = 5;
    do_byte(8'h3C, 1'b1, 1, 8'h81, 1'b0, 0, 8'h00, 0);
    hold_en = 1'b0;

    do_byte(8'h12, 1'b1, 0, 8'h00, 1'b0, 0, 8'h00, 1);
    do_byte(8'h34, 1'b0, 2, 8'h77, 1'b0, 1, 8'h01, 0);
    do_byte(8'h56, 1'b1, 0, 8'h99, 1'b0, 0, 8'h00, 2);
    do_byte(8'h78, 1'b1, 0, 8'h42, 1'b0, 2, 8'h10, 0);
    do_byte(8'h9A, 1'b0, 0, 8'h11, 1'b1, 0, 8'h00, 3);

    for (int i = 0; i < 24; i++) begin
      int m;
      m = int'($urandom_range(0, 5));
      do_byte(8'($urandom), 1'($urandom), int'($urandom_range(0, 4)), 8'($urandom),
              1'($urandom), (m > 2) ? 0 : m, 8'($urandom), 0);
    end

    // Async reset in the middle of a transfer must clear the bus immediately.
    @(negedge PCLK);
    req_valid = 1'b1; req_data = 8'hC3; req_cs = ss_m;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    chk_val("pre_arst_psel", 32'(PSEL), 32'd1);
    @(posedge PCLK);
    #2 PRESETN = 1'b0;
    #1;
    chk_val("arst_psel", 32'(PSEL), 32'd0);
    chk_val("arst_penable", 32'(PENABLE), 32'd0);
    chk_val("arst_busy", 32'(busy), 32'd1);
    chk_val("arst_rspd", 32'(rsp_data), 32'd0);

    repeat (2) @(negedge PCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
